// File: rtl/sd_host_pkg.sv
// sd_host_pkg: shared definitions for the SD host control/status path.
//
// Contents:
//   BANK_LANES / REQ_W  default lane count of the register port and the width
//                       of its request-count field
//   acc_dir_e           access direction carried on wnr
//   bank_req_ok()       range/size check for a register-bank access
//
// Access encoding on the register port:
//   wnr = 1 : write, wnr = 0 : read
//   req = number of consecutive registers touched, starting at address;
//         req = 0 means no access this cycle
//   lane k of data_in/data_out corresponds to register address+k
package sd_host_pkg;

  localparam int unsigned BANK_LANES = 4;
  localparam int unsigned REQ_W      = $clog2(BANK_LANES + 1);

  typedef enum logic {
    ACC_READ  = 1'b0,
    ACC_WRITE = 1'b1
  } acc_dir_e;

  // An access is legal when it touches between 1 and lanes registers and does
  // not run past the last register. Arguments are widened to 32 bits so the
  // end-address sum cannot wrap for any realistic ADDR_WIDTH.
  function automatic logic bank_req_ok(input int unsigned address,
                                       input int unsigned req,
                                       input int unsigned lanes,
                                       input int unsigned depth);
    return (req != 0) && (req <= lanes) && ((address + req) <= depth);
  endfunction

endpackage

// File: rtl/register_bank_cell.sv
// register_bank_cell: one DATA_WIDTH-bit control/status register.
//
// Each bit behaves according to its mask class:
//   RO_MASK bit   : follows hw_status_i every cycle, ignores software writes
//   W1C_MASK bit  : sticky status; hw_set_i ORs it in, a software 1 clears it,
//                   hw_set_i wins when both happen on the same edge
//   other bits    : plain read/write storage
//
// Ports:
//   clk_i        clock
//   rst_ni       asynchronous active-low reset (loads RESET_VALUE)
//   we_i         software write strobe for this register
//   wdata_i      software write data
//   hw_set_i     OR-set pulses for W1C bits
//   hw_status_i  live value for RO bits
//   q_o          current register value
//   w1c_pend_o   some W1C bit will be set after the coming edge
module register_bank_cell
  import sd_host_pkg::*;
#(
  parameter int unsigned            DATA_WIDTH  = 8,
  parameter logic [DATA_WIDTH-1:0]  RESET_VALUE = '0,
  parameter logic [DATA_WIDTH-1:0]  RO_MASK     = '0,
  parameter logic [DATA_WIDTH-1:0]  W1C_MASK    = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  we_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [DATA_WIDTH-1:0] hw_set_i,
  input  logic [DATA_WIDTH-1:0] hw_status_i,
  output logic [DATA_WIDTH-1:0] q_o,
  output logic                  w1c_pend_o
);

  // A bit marked both RO and W1C is treated as RO.
  localparam logic [DATA_WIDTH-1:0] W1C_EFF = W1C_MASK & ~RO_MASK;
  localparam logic [DATA_WIDTH-1:0] RW_EFF  = ~RO_MASK & ~W1C_MASK;

  logic [DATA_WIDTH-1:0] q_q;
  logic [DATA_WIDTH-1:0] q_d;
  logic [DATA_WIDTH-1:0] wr_val;
  logic [DATA_WIDTH-1:0] sw_clr;

  always_comb begin
    wr_val = we_i ? wdata_i : q_q;
    sw_clr = we_i ? wdata_i : '0;
    q_d    = (hw_status_i & RO_MASK)
           | (((q_q & ~sw_clr) | hw_set_i) & W1C_EFF)
           | (wr_val & RW_EFF);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q <= RESET_VALUE;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o        = q_q;
  assign w1c_pend_o = |(q_d & W1C_EFF);

endmodule

// File: rtl/register_bank.sv
// register_bank: byte-addressed control/status register file for the SD host.
//
// A request of 1..LANES consecutive registers is sampled on every rising edge
// where req != 0; the response (ack, err, data_out) is registered and appears
// for exactly one cycle after the request edge. Out-of-range or oversized
// requests are answered with ack+err and change nothing.
//
// Ports:
//   clk           clock
//   reset         asynchronous active-low reset
//   wnr           1 = write, 0 = read
//   req           registers in this access, 0 = idle
//   address       first register of the access
//   data_in       write data, lane k -> address+k
//   hw_set        OR-set pulses into W1C bits (whole image)
//   hw_status     live values for RO bits (whole image)
//   ack           one-cycle response strobe
//   err           request rejected (qualifies ack)
//   data_out      read data, lane k <- address+k, zero above req
//   mem_data_out  full register image
//   irq           registered OR of all set W1C bits
module register_bank
  import sd_host_pkg::*;
#(
  parameter int unsigned                       DATA_WIDTH  = 8,
  parameter int unsigned                       ADDR_WIDTH  = 8,
  parameter int unsigned                       MEM_DEPTH   = 1 << ADDR_WIDTH,
  parameter int unsigned                       LANES       = 4,
  parameter logic [DATA_WIDTH*MEM_DEPTH-1:0]   RESET_VALUE = '0,
  parameter logic [DATA_WIDTH*MEM_DEPTH-1:0]   RO_MASK     = '0,
  parameter logic [DATA_WIDTH*MEM_DEPTH-1:0]   W1C_MASK    = '0
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              wnr,
  input  logic [$clog2(LANES+1)-1:0]        req,
  input  logic [ADDR_WIDTH-1:0]             address,
  input  logic [LANES*DATA_WIDTH-1:0]       data_in,
  input  logic [DATA_WIDTH*MEM_DEPTH-1:0]   hw_set,
  input  logic [DATA_WIDTH*MEM_DEPTH-1:0]   hw_status,
  output logic                              ack,
  output logic                              err,
  output logic [LANES*DATA_WIDTH-1:0]       data_out,
  output logic [DATA_WIDTH*MEM_DEPTH-1:0]   mem_data_out,
  output logic                              irq
);

  acc_dir_e                    dir;
  logic                        req_any;
  logic                        req_ok;
  logic                        wr_en;
  logic                        rd_en;

  logic [DATA_WIDTH-1:0]       mem_q [MEM_DEPTH];
  logic [MEM_DEPTH-1:0]        w1c_pend;

  logic                        ack_q, ack_d;
  logic                        err_q, err_d;
  logic                        irq_q, irq_d;
  logic [LANES*DATA_WIDTH-1:0] rdata_q, rdata_d;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  assign dir     = acc_dir_e'(wnr);
  assign req_any = (req != '0);
  assign req_ok  = bank_req_ok(32'(address), 32'(req), LANES, MEM_DEPTH);
  assign wr_en   = req_ok && (dir == ACC_WRITE);
  assign rd_en   = req_ok && (dir == ACC_READ);

  // ---------------------------------------------------------------------------
  // Register cells with write-lane steering
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < MEM_DEPTH; i++) begin : g_cell
    logic                  we;
    logic [DATA_WIDTH-1:0] wdata;

    // Register i is hit by lane k when address+k == i and k is below req.
    always_comb begin
      we    = 1'b0;
      wdata = '0;
      for (int unsigned k = 0; k < LANES; k++) begin
        if (wr_en && (k < 32'(req)) && ((32'(address) + k) == 32'(i))) begin
          we    = 1'b1;
          wdata = data_in[k*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end

    register_bank_cell #(
      .DATA_WIDTH  (DATA_WIDTH),
      .RESET_VALUE (RESET_VALUE[i*DATA_WIDTH +: DATA_WIDTH]),
      .RO_MASK     (RO_MASK[i*DATA_WIDTH +: DATA_WIDTH]),
      .W1C_MASK    (W1C_MASK[i*DATA_WIDTH +: DATA_WIDTH])
    ) u_cell (
      .clk_i       (clk),
      .rst_ni      (reset),
      .we_i        (we),
      .wdata_i     (wdata),
      .hw_set_i    (hw_set[i*DATA_WIDTH +: DATA_WIDTH]),
      .hw_status_i (hw_status[i*DATA_WIDTH +: DATA_WIDTH]),
      .q_o         (mem_q[i]),
      .w1c_pend_o  (w1c_pend[i])
    );

    assign mem_data_out[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[i];
  end

  // ---------------------------------------------------------------------------
  // Read lane steering: values from before the edge, zero above req
  // ---------------------------------------------------------------------------
  always_comb begin
    rdata_d = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      if (rd_en && (k < 32'(req))) begin
        rdata_d[k*DATA_WIDTH +: DATA_WIDTH] = mem_q[ADDR_WIDTH'(32'(address) + k)];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Response and interrupt registers
  // ---------------------------------------------------------------------------
  always_comb begin
    ack_d = req_any;
    err_d = req_any && !req_ok;
    // Uses the cells' next-state so irq matches the image after the edge.
    irq_d = |w1c_pend;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      irq_q   <= irq_d;
    end
  end

  assign ack      = ack_q;
  assign err      = err_q;
  assign data_out = rdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_register_bank.sv
module tb_register_bank;

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 8;
  localparam int unsigned DEPTH = 256;
  localparam int unsigned LANES = 4;
  localparam int unsigned IW    = DW * DEPTH;

  // reset image: regs 0/1 = 5A/A5; W1C: reg 0x20 = FF, 0x21 = F0; RO: 0x30 = 0F, 0x31 = FF
  localparam logic [IW-1:0] RV  = IW'(16'hA55A);
  localparam logic [IW-1:0] W1C = IW'(16'hF0FF) << (8 * 32);
  localparam logic [IW-1:0] RO  = IW'(16'hFF0F) << (8 * 48);

  logic          clk;
  logic          rst_n;
  logic          wnr;
  logic [2:0]    req;
  logic [AW-1:0] address;
  logic [31:0]   data_in;
  logic [IW-1:0] hw_set;
  logic [IW-1:0] hw_status;
  logic          ack;
  logic          err;
  logic [31:0]   data_out;
  logic [IW-1:0] mem_data_out;
  logic          irq;

  register_bank #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .MEM_DEPTH   (DEPTH),
    .LANES       (LANES),
    .RESET_VALUE (RV),
    .RO_MASK     (RO),
    .W1C_MASK    (W1C)
  ) dut (
    .clk          (clk),
    .reset        (rst_n),
    .wnr          (wnr),
    .req          (req),
    .address      (address),
    .data_in      (data_in),
    .hw_set       (hw_set),
    .hw_status    (hw_status),
    .ack          (ack),
    .err          (err),
    .data_out     (data_out),
    .mem_data_out (mem_data_out),
    .irq          (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } resp_t;

  logic [7:0]    model [DEPTH];
  logic          model_irq;
  resp_t         sb [$];
  logic [IW-1:0] set_v;
  logic [IW-1:0] stat_v;
  int            n_cmp;
  int            n_bad;
  resp_t         mon_e;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic legal(input int unsigned r, input int unsigned a);
    return (r >= 1) && (r <= LANES) && (a + r <= DEPTH);
  endfunction

  task automatic model_reset();
    for (int unsigned i = 0; i < DEPTH; i++) model[i] = RV[8*i +: 8];
    model_irq = 1'b0;
  endtask

  // One clock edge of the bank, bit by bit from the access rules.
  task automatic model_step(input logic w, input int unsigned r, input int unsigned a,
                            input logic [31:0] d);
    logic [7:0] nxt [DEPTH];
    logic [7:0] ro, wc, st, hs, wb;
    logic       hit;
    logic       anyirq;
    anyirq = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      ro  = RO[8*i +: 8];
      wc  = W1C[8*i +: 8];
      st  = stat_v[8*i +: 8];
      hs  = set_v[8*i +: 8];
      hit = legal(r, a) && w && (i >= a) && (i < a + r);
      wb  = 8'h00;
      if (hit) wb = d[8*(i-a) +: 8];
      for (int unsigned b = 0; b < 8; b++) begin
        if (ro[b])      nxt[i][b] = st[b];
        else if (wc[b]) nxt[i][b] = hs[b] | (model[i][b] & !(hit && wb[b]));
        else            nxt[i][b] = hit ? wb[b] : model[i][b];
        if (wc[b] && !ro[b] && nxt[i][b]) anyirq = 1'b1;
      end
    end
    for (int unsigned i = 0; i < DEPTH; i++) model[i] = nxt[i];
    model_irq = anyirq;
  endtask

  // Drive one request on the falling edge; at the rising edge record the
  // expected response and advance the model.
  task automatic cycle(input logic w, input int unsigned r, input int unsigned a,
                       input logic [31:0] d);
    resp_t e;
    @(negedge clk);
    wnr = w; req = 3'(r); address = 8'(a); data_in = d;
    hw_set = set_v; hw_status = stat_v;
    @(posedge clk);
    if (r != 0) begin
      e.err  = !legal(r, a);
      e.data = '0;
      if (legal(r, a) && !w)
        for (int unsigned k = 0; k < r; k++) e.data[8*k +: 8] = model[a+k];
      sb.push_back(e);
    end
    model_step(w, r, a, d);
    set_v = '0;
  endtask

  task automatic check_reg(input string name, input int unsigned r, input logic [7:0] exp);
    #1;
    check(name, 64'(mem_data_out[8*r +: 8]), 64'(exp));
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1; req = '0; hw_set = '0; set_v = '0; hw_status = stat_v;
    @(posedge clk);
    model_step(1'b0, 0, 0, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req = '0; hw_set = '0; set_v = '0;
    sb.delete();
    model_reset();
    #1;
    check("rst_ack", 64'(ack), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    check("rst_data", 64'(data_out), 64'(0));
    check("rst_irq", 64'(irq), 64'(0));
    repeat (2) @(negedge clk);
    check("rst_image_lo", 64'(mem_data_out[15:0]), 64'(16'hA55A));
    release_reset();
  endtask

  // Reset arrives just before the edge that would sample a write.
  task automatic reset_during_req();
    @(negedge clk);
    wnr = 1'b1; req = 3'd1; address = 8'h05; data_in = 32'h99; hw_set = '0;
    #4;
    rst_n = 1'b0;
    sb.delete();
    model_reset();
    @(posedge clk);
    #1;
    check("drop_ack", 64'(ack), 64'(0));
    check("drop_reg05", 64'(mem_data_out[8*5 +: 8]), 64'(0));
    check("drop_reg00", 64'(mem_data_out[7:0]), 64'(8'h5A));
    release_reset();
  endtask

  // Monitor: pops an expected response whenever the DUT acknowledges.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ack) begin
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_ack: got ack=1, expected no ack (t=%0t)", $time);
        end else begin
          mon_e = sb.pop_front();
          check("resp_err", 64'(err), 64'(mon_e.err));
          check("resp_data", 64'(data_out), 64'(mon_e.data));
        end
      end else begin
        if (sb.size() != 0) begin
          n_cmp++; n_bad++;
          void'(sb.pop_front());
          $display("FAIL missing_ack: got ack=0, expected ack=1 (t=%0t)", $time);
        end
        check("idle_err", 64'(err), 64'(0));
        check("idle_data", 64'(data_out), 64'(0));
      end
      check("irq", 64'(irq), 64'(model_irq));
      begin : img
        int unsigned bad_i;
        bit          bad;
        bad = 1'b0; bad_i = 0;
        for (int unsigned i = 0; i < DEPTH; i++)
          if (!bad && mem_data_out[8*i +: 8] !== model[i]) begin bad = 1'b1; bad_i = i; end
        n_cmp++;
        if (bad) begin
          n_bad++;
          $display("FAIL image reg %0h: got %0h, expected %0h (t=%0t)",
                   bad_i, mem_data_out[8*bad_i +: 8], model[bad_i], $time);
        end
      end
    end
  end

  initial begin
    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0; wnr = 1'b0; req = '0; address = '0; data_in = '0;
    hw_set = '0; hw_status = '0; set_v = '0; stat_v = '0;
    model_reset();
    do_reset();

    // multi-lane write and reads
    cycle(1'b1, 4, 8'h10, 32'h44332211);
    check_reg("wr_reg10", 8'h10, 8'h11);
    cycle(1'b0, 4, 8'h10, 32'h0);
    cycle(1'b0, 2, 8'h11, 32'h0);
    cycle(1'b0, 0, 0, 32'h0);

    // W1C behaviour
    set_v[8*32 +: 8] = 8'h08;
    cycle(1'b0, 0, 0, 32'h0);
    check_reg("w1c_set", 8'h20, 8'h08);
    check("w1c_irq_on", 64'(irq), 64'(1));
    cycle(1'b1, 1, 8'h20, 32'h08);
    check_reg("w1c_clr", 8'h20, 8'h00);
    check("w1c_irq_off", 64'(irq), 64'(0));
    set_v[8*32 +: 8] = 8'h08;
    cycle(1'b1, 1, 8'h20, 32'h08);
    check_reg("w1c_set_wins", 8'h20, 8'h08);

    // RO behaviour
    stat_v[8*48 +: 8] = 8'h05;
    cycle(1'b1, 1, 8'h30, 32'hFA);
    check_reg("ro_write", 8'h30, 8'hF5);
    stat_v[8*48 +: 8] = 8'h0C;
    cycle(1'b0, 0, 0, 32'h0);
    check_reg("ro_status", 8'h30, 8'hFC);

    // range and size checks
    cycle(1'b1, 2, 8'hFF, 32'hDEADBEEF);
    cycle(1'b0, 5, 8'h00, 32'h0);
    cycle(1'b1, 5, 8'h40, 32'h12345678);
    cycle(1'b1, 1, 8'hFF, 32'h77);
    cycle(1'b0, 1, 8'hFF, 32'h0);
    cycle(1'b0, 4, 8'hFC, 32'h0);
    cycle(1'b0, 4, 8'hFD, 32'h0);

    // back-to-back write then read
    cycle(1'b1, 3, 8'h50, 32'h00C0FFEE);
    cycle(1'b0, 3, 8'h50, 32'h0);

    // reset in the middle of a request
    cycle(1'b1, 1, 8'h05, 32'h3C);
    reset_during_req();

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      int unsigned a, r, sel;
      logic        w;
      sel = $urandom % 4;
      if (sel == 0)      a = 8'hFA + ($urandom % 6);
      else if (sel == 1) a = 8'h1E + ($urandom % 20);
      else               a = $urandom % 256;
      a = a % 256;
      r = $urandom % 6;
      w = 1'($urandom);
      if ($urandom % 4 == 0) set_v[8*(32 + $urandom % 2) +: 8] = 8'($urandom);
      if ($urandom % 4 == 0) stat_v[8*(48 + $urandom % 2) +: 8] = 8'($urandom);
      if ($urandom % 8 == 0) stat_v[8*($urandom % 256) +: 8] = 8'($urandom);
      cycle(w, r, a, $urandom);
    end
    cycle(1'b0, 0, 0, 32'h0);
    cycle(1'b0, 0, 0, 32'h0);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
